seven_seg_scan_ctrl: RTL and testbench

//  Bus-mapped controller that time-multiplexes a 4-digit common-anode seven-segment display.

---
 rtl/seven_seg_pkg.sv | 33 +++
 rtl/seven_seg_scan_ctrl_if.sv | 9 +
 rtl/seven_seg_scan_ctrl_seg_decoder.sv | 13 +
 rtl/seven_seg_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller: register offsets,
// CTRL bit positions and the active-low segment encoding table.
package seven_seg_pkg;

  localparam logic [7:0] OFS_DIG_LO = 8'd0;
  localparam logic [7:0] OFS_DIG_HI = 8'd1;
  localparam logic [7:0] OFS_MASK   = 8'd2;
  localparam logic [7:0] OFS_CTRL   = 8'd3;
  localparam logic [7:0] OFS_CLEAR  = 8'd4;

  localparam int CTRL_BLANK_BIT = 0;
  localparam int CTRL_LZS_BIT   = 1;

  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [7:0] SEG_DP_ONLY = 8'h7F;
  localparam logic [3:0] SEL_OFF     = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [2:0] {
    REG_DIG_LO,
    REG_DIG_HI,
    REG_MASK,
    REG_CTRL,
    REG_CLEAR,
    REG_NONE
  } reg_sel_e;

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Processor-side write bus into the scan controller.
interface seven_seg_scan_ctrl_if;
  logic       bus_we;
  logic [7:0] addr;
  logic [7:0] data_in;

  modport master (output bus_we, output addr, output data_in);
  modport slave  (input  bus_we, input  addr, input  data_in);
endinterface

// File: rtl/seven_seg_scan_ctrl_seg_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 4-digit common-anode display controller: bus-written registers, refresh
// prescaler, digit scanner, leading-zero suppression and registered pin drivers.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'hD0,
  parameter int         REFRESH_DIV = 100000,
  parameter int         DIV_WIDTH   = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  seven_seg_scan_ctrl_if.slave bus,
  output logic [3:0]           seg_select_out,
  output logic [7:0]           hex_out
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

  logic [7:0]           dig_lo_q, dig_lo_d;
  logic [7:0]           dig_hi_q, dig_hi_d;
  logic [7:0]           mask_q, mask_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0]           sel_q, sel_d;
  logic [7:0]           hex_q, hex_d;

  logic [7:0] addr_ofs;
  reg_sel_e   reg_sel;
  logic       tick;
  logic [3:0] nib [4];
  logic [3:0] dp;
  logic [3:0] digit_en;
  logic       blank_all;
  logic       lzs;
  logic [3:0] lead_zero;
  logic       higher_zero;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic [3:0] cur_sel;
  logic       suppress;

  always_comb begin
    addr_ofs = bus.addr - BASE_ADDR;
    reg_sel  = REG_NONE;
    if (bus.bus_we) begin
      case (addr_ofs)
        OFS_DIG_LO: reg_sel = REG_DIG_LO;
        OFS_DIG_HI: reg_sel = REG_DIG_HI;
        OFS_MASK:   reg_sel = REG_MASK;
        OFS_CTRL:   reg_sel = REG_CTRL;
        OFS_CLEAR:  reg_sel = REG_CLEAR;
        default:    reg_sel = REG_NONE;
      endcase
    end
  end

  always_comb begin
    dig_lo_d = dig_lo_q;
    dig_hi_d = dig_hi_q;
    mask_d   = mask_q;
    ctrl_d   = ctrl_q;
    case (reg_sel)
      REG_DIG_LO: dig_lo_d = bus.data_in;
      REG_DIG_HI: dig_hi_d = bus.data_in;
      REG_MASK:   mask_d   = bus.data_in;
      REG_CTRL:   ctrl_d   = bus.data_in[1:0];
      REG_CLEAR: begin
        dig_lo_d = '0;
        dig_hi_d = '0;
        mask_d   = '0;
        ctrl_d   = '0;
      end
      default: ;
    endcase
  end

  // The scanner advances on tick regardless of any register write that cycle.
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;
  end

  always_comb begin
    nib[0]    = dig_lo_q[3:0];
    nib[1]    = dig_lo_q[7:4];
    nib[2]    = dig_hi_q[3:0];
    nib[3]    = dig_hi_q[7:4];
    dp        = mask_q[3:0];
    digit_en  = mask_q[7:4];
    blank_all = ctrl_q[CTRL_BLANK_BIT];
    lzs       = ctrl_q[CTRL_LZS_BIT];
  end

  // Walk from the top digit down; disabled digits never break a run of leading zeros.
  always_comb begin
    lead_zero   = '0;
    higher_zero = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      lead_zero[k] = higher_zero && (nib[k] == 4'd0);
      if (digit_en[k] && (nib[k] != 4'd0)) begin
        higher_zero = 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib = nib[idx_q];
  end

  seg_decoder u_seg_decoder (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_comb begin
    sel_d    = SEL_OFF;
    hex_d    = SEG_OFF;
    cur_sel  = ~(4'b0001 << idx_q);
    suppress = lzs && (idx_q != 2'd0) && lead_zero[idx_q];
    if (digit_en[idx_q] && !blank_all) begin
      if (suppress) begin
        if (dp[idx_q]) begin
          sel_d = cur_sel;
          hex_d = SEG_DP_ONLY;
        end
      end else begin
        sel_d = cur_sel;
        hex_d = {~dp[idx_q], cur_seg};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dig_lo_q <= '0;
      dig_hi_q <= '0;
      mask_q   <= '0;
      ctrl_q   <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      sel_q    <= SEL_OFF;
      hex_q    <= SEG_OFF;
    end else begin
      dig_lo_q <= dig_lo_d;
      dig_hi_q <= dig_hi_d;
      mask_q   <= mask_d;
      ctrl_q   <= ctrl_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      hex_q    <= hex_d;
    end
  end

  assign seg_select_out = sel_q;
  assign hex_out        = hex_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a 4-clock refresh slot.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] seg_select_out;
  logic [7:0] hex_out;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  seven_seg_scan_ctrl_if bus_if();

  seven_seg_scan_ctrl #(
    .BASE_ADDR   (8'hD0),
    .REFRESH_DIV (4),
    .DIV_WIDTH   (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_if),
    .seg_select_out (seg_select_out),
    .hex_out        (hex_out)
  );

  always #5 clk = ~clk;

  // cyc counts edges since reset release; edge c shows slot ((c-1)/4)%4.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_if.bus_we  = 1'b1;
    bus_if.addr    = a;
    bus_if.data_in = d;
    step();
    bus_if.bus_we  = 1'b0;
    bus_if.addr    = 8'h00;
    bus_if.data_in = 8'h00;
  endtask

  task automatic align_slot0();
    while ((cyc % 16) != 0) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({seg_select_out, hex_out} !== 12'hFFF) begin
        bad++;
        $display("[TB] FAIL reset_hold: got %b/%h want 1111/ff", seg_select_out, hex_out);
      end
    end
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if ({seg_select_out, hex_out} !== 12'hFFF) begin
        bad++;
        $display("[TB] FAIL reset_dark c=%0d: got %b/%h want 1111/ff", cyc, seg_select_out, hex_out);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_sel [4];
    logic [7:0] exp_hex [4];
    int s;
    exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_hex = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
    bus_write(8'hD0, 8'h21);
    bus_write(8'hD1, 8'h43);
    bus_write(8'hD2, 8'hF0);
    bus_write(8'hD5, 8'hFF);
    bus_write(8'hCF, 8'hFF);
    align_slot0();
    for (int i = 0; i < 32; i++) begin
      step();
      s = ((cyc - 1) % 16) / 4;
      total++;
      if (seg_select_out !== exp_sel[s] || hex_out !== exp_hex[s]) begin
        bad++;
        $display("[TB] FAIL scan slot%0d: got %b/%h want %b/%h", s, seg_select_out, hex_out, exp_sel[s], exp_hex[s]);
      end
    end
  endtask

  task automatic test_dp_enable();
    logic [3:0] exp_sel [4];
    logic [7:0] exp_hex [4];
    int s;
    exp_sel = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    exp_hex = '{8'h79, 8'hA4, 8'hFF, 8'hFF};
    bus_write(8'hD2, 8'h35);
    align_slot0();
    for (int i = 0; i < 16; i++) begin
      step();
      s = ((cyc - 1) % 16) / 4;
      total++;
      if (seg_select_out !== exp_sel[s] || hex_out !== exp_hex[s]) begin
        bad++;
        $display("[TB] FAIL dp_enable slot%0d: got %b/%h want %b/%h", s, seg_select_out, hex_out, exp_sel[s], exp_hex[s]);
      end
    end
  endtask

  task automatic test_decode();
    logic [7:0] lo [3];
    logic [7:0] hi [3];
    logic [7:0] exp_hex [3][4];
    logic [3:0] exp_sel [4];
    int s;
    lo      = '{8'hBA, 8'h76, 8'h98};
    hi      = '{8'hDC, 8'hFE, 8'h54};
    exp_hex = '{'{8'h88, 8'h83, 8'hC6, 8'hA1},
                '{8'h82, 8'hF8, 8'h86, 8'h8E},
                '{8'h80, 8'h90, 8'h99, 8'h92}};
    exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bus_write(8'hD2, 8'hF0);
    for (int v = 0; v < 3; v++) begin
      bus_write(8'hD0, lo[v]);
      bus_write(8'hD1, hi[v]);
      align_slot0();
      for (int i = 0; i < 16; i++) begin
        step();
        s = ((cyc - 1) % 16) / 4;
        total++;
        if (seg_select_out !== exp_sel[s] || hex_out !== exp_hex[v][s]) begin
          bad++;
          $display("[TB] FAIL decode v%0d slot%0d: got %b/%h want %b/%h", v, s, seg_select_out, hex_out, exp_sel[s], exp_hex[v][s]);
        end
      end
    end
  endtask

  task automatic test_lzs();
    logic [3:0] exp_sel [3][4];
    logic [7:0] exp_hex [3][4];
    int s;
    exp_sel = '{'{4'b1110, 4'b1111, 4'b1011, 4'b1111},
                '{4'b1110, 4'b1111, 4'b1111, 4'b1111},
                '{4'b1110, 4'b1101, 4'b1011, 4'b0111}};
    exp_hex = '{'{8'h92, 8'hFF, 8'h7F, 8'hFF},
                '{8'hC0, 8'hFF, 8'hFF, 8'hFF},
                '{8'hC0, 8'hC0, 8'hC0, 8'h92}};
    for (int v = 0; v < 3; v++) begin
      case (v)
        0: begin
          bus_write(8'hD0, 8'h05);
          bus_write(8'hD1, 8'h00);
          bus_write(8'hD2, 8'hF4);
          bus_write(8'hD3, 8'h02);
        end
        1: begin
          bus_write(8'hD0, 8'h00);
          bus_write(8'hD1, 8'h50);
          bus_write(8'hD2, 8'h70);
        end
        default: bus_write(8'hD2, 8'hF0);
      endcase
      align_slot0();
      for (int i = 0; i < 16; i++) begin
        step();
        s = ((cyc - 1) % 16) / 4;
        total++;
        if (seg_select_out !== exp_sel[v][s] || hex_out !== exp_hex[v][s]) begin
          bad++;
          $display("[TB] FAIL lzs v%0d slot%0d: got %b/%h want %b/%h", v, s, seg_select_out, hex_out, exp_sel[v][s], exp_hex[v][s]);
        end
      end
    end
  endtask

  task automatic test_blank_clear();
    logic [3:0] exp_sel [4];
    int s;
    exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bus_write(8'hD3, 8'h01);
    align_slot0();
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if ({seg_select_out, hex_out} !== 12'hFFF) begin
        bad++;
        $display("[TB] FAIL blank_all c=%0d: got %b/%h want 1111/ff", cyc, seg_select_out, hex_out);
      end
    end
    bus_write(8'hD4, 8'h5A);
    align_slot0();
    for (int i = 0; i < 16; i++) begin
      step();
      total++;
      if ({seg_select_out, hex_out} !== 12'hFFF) begin
        bad++;
        $display("[TB] FAIL clear_dark c=%0d: got %b/%h want 1111/ff", cyc, seg_select_out, hex_out);
      end
    end
    bus_write(8'hD2, 8'hF0);
    align_slot0();
    for (int i = 0; i < 16; i++) begin
      step();
      s = ((cyc - 1) % 16) / 4;
      total++;
      if (seg_select_out !== exp_sel[s] || hex_out !== 8'hC0) begin
        bad++;
        $display("[TB] FAIL clear_zeros slot%0d: got %b/%h want %b/c0", s, seg_select_out, hex_out, exp_sel[s]);
      end
    end
  endtask

  task automatic test_collision();
    while ((cyc % 16) != 3) step();
    bus_write(8'hD0, 8'h08);
    total++;
    if (seg_select_out !== 4'b1110 || hex_out !== 8'hC0) begin
      bad++;
      $display("[TB] FAIL collide_old: got %b/%h want 1110/c0", seg_select_out, hex_out);
    end
    step();
    total++;
    if (seg_select_out !== 4'b1101 || hex_out !== 8'hC0) begin
      bad++;
      $display("[TB] FAIL collide_next: got %b/%h want 1101/c0", seg_select_out, hex_out);
    end
    align_slot0();
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (seg_select_out !== 4'b1110 || hex_out !== 8'h80) begin
        bad++;
        $display("[TB] FAIL collide_new c=%0d: got %b/%h want 1110/80", cyc, seg_select_out, hex_out);
      end
    end
    // CLEAR landing on a tick edge: clear wins, scanner still steps.
    while ((cyc % 16) != 11) step();
    bus_write(8'hD4, 8'h00);
    total++;
    if (seg_select_out !== 4'b1011 || hex_out !== 8'hC0) begin
      bad++;
      $display("[TB] FAIL clear_tick_old: got %b/%h want 1011/c0", seg_select_out, hex_out);
    end
    bus_write(8'hD2, 8'hF0);
    total++;
    if ({seg_select_out, hex_out} !== 12'hFFF) begin
      bad++;
      $display("[TB] FAIL clear_tick_dark: got %b/%h want 1111/ff", seg_select_out, hex_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (seg_select_out !== 4'b0111 || hex_out !== 8'hC0) begin
        bad++;
        $display("[TB] FAIL clear_tick_slot3 c=%0d: got %b/%h want 0111/c0", cyc, seg_select_out, hex_out);
      end
    end
    step();
    total++;
    if (seg_select_out !== 4'b1110 || hex_out !== 8'hC0) begin
      bad++;
      $display("[TB] FAIL clear_tick_slot0: got %b/%h want 1110/c0", seg_select_out, hex_out);
    end
  endtask

  task automatic test_reset_mid_scan();
    while ((cyc % 16) != 6) step();
    reset = 1'b1;
    step();
    total++;
    if ({seg_select_out, hex_out} !== 12'hFFF) begin
      bad++;
      $display("[TB] FAIL mid_reset: got %b/%h want 1111/ff", seg_select_out, hex_out);
    end
    reset = 1'b0;
    cyc   = 0;
    bus_write(8'hD2, 8'hF0);
    total++;
    if ({seg_select_out, hex_out} !== 12'hFFF) begin
      bad++;
      $display("[TB] FAIL restart_dark: got %b/%h want 1111/ff", seg_select_out, hex_out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (seg_select_out !== 4'b1110 || hex_out !== 8'hC0) begin
        bad++;
        $display("[TB] FAIL restart_slot0 c=%0d: got %b/%h want 1110/c0", cyc, seg_select_out, hex_out);
      end
    end
    step();
    total++;
    if (seg_select_out !== 4'b1101 || hex_out !== 8'hC0) begin
      bad++;
      $display("[TB] FAIL restart_slot1: got %b/%h want 1101/c0", seg_select_out, hex_out);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus_if.bus_we  = 1'b0;
    bus_if.addr    = 8'h00;
    bus_if.data_in = 8'h00;
    test_reset();
    test_scan();
    test_dp_enable();
    test_decode();
    test_lzs();
    test_blank_clear();
    test_collision();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
